// File: rtl/level_gen_pkg.sv
// Shared types and default hold lengths for the level generator slice.
package level_gen_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        HOLD_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        HOLD_LOW  = 2'd3
    } level_state_t;

    localparam int DEFAULT_MIN_HIGH = 4;
    localparam int DEFAULT_MIN_LOW  = 4;

endpackage

// File: rtl/level_gen_hold_cnt.sv
// Down-counter that times a minimum-hold interval; zero flag marks expiry.
module level_gen_hold_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Load has priority so a back-to-back hold restarts cleanly from expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/level_generator.sv
// Pulse-driven level output that enforces minimum high and low widths,
// remembering one late opposite request while a hold interval runs.
module level_generator
    import level_gen_pkg::*;
#(
    parameter int MIN_HIGH = DEFAULT_MIN_HIGH,
    parameter int MIN_LOW  = DEFAULT_MIN_LOW,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in_p,
    input  logic pulse_in_n,
    output logic sig_out,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] LOAD_HIGH = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LOAD_LOW  = CNT_W'(MIN_LOW - 1);

    level_state_t     r_state;
    logic             r_pending;
    logic             r_sig;
    logic             r_busy;
    logic             r_conflict;

    logic             w_req_p;
    logic             w_req_n;
    logic             w_load_high;
    logic             w_load_low;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_cnt_zero;

    // Simultaneous requests cancel out; only a lone pulse counts as a request.
    always_comb begin
        w_req_p     = pulse_in_p & ~pulse_in_n;
        w_req_n     = pulse_in_n & ~pulse_in_p;
        w_load_high = 1'b0;
        w_load_low  = 1'b0;
        case (r_state)
            IDLE_LOW:  w_load_high = w_req_p;
            HOLD_HIGH: w_load_low  = w_cnt_zero & (r_pending | w_req_n);
            IDLE_HIGH: w_load_low  = w_req_n;
            HOLD_LOW:  w_load_high = w_cnt_zero & (r_pending | w_req_p);
            default:   ;
        endcase
        w_load     = w_load_high | w_load_low;
        w_load_val = w_load_high ? LOAD_HIGH : LOAD_LOW;
        w_dec      = ((r_state == HOLD_HIGH) || (r_state == HOLD_LOW)) && !w_cnt_zero;
    end

    level_gen_hold_cnt #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE_LOW;
            r_pending  <= 1'b0;
            r_sig      <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= pulse_in_p & pulse_in_n;
            case (r_state)
                IDLE_LOW: begin
                    r_pending <= 1'b0;
                    if (w_load_high) begin
                        r_state <= HOLD_HIGH;
                        r_sig   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                HOLD_HIGH: begin
                    if (w_cnt_zero) begin
                        r_pending <= 1'b0;
                        if (w_load_low) begin
                            r_state <= HOLD_LOW;
                            r_sig   <= 1'b0;
                        end else begin
                            r_state <= IDLE_HIGH;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_req_n) begin
                        r_pending <= 1'b1;
                    end else if (w_req_p) begin
                        r_pending <= 1'b0;
                    end
                end
                IDLE_HIGH: begin
                    r_pending <= 1'b0;
                    if (w_load_low) begin
                        r_state <= HOLD_LOW;
                        r_sig   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                HOLD_LOW: begin
                    if (w_cnt_zero) begin
                        r_pending <= 1'b0;
                        if (w_load_high) begin
                            r_state <= HOLD_HIGH;
                            r_sig   <= 1'b1;
                        end else begin
                            r_state <= IDLE_LOW;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_req_p) begin
                        r_pending <= 1'b1;
                    end else if (w_req_n) begin
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE_LOW;
                    r_pending <= 1'b0;
                    r_sig     <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sig_out  = r_sig;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_level_generator.sv
// Directed-vector scoreboard bench for level_generator with MIN_HIGH=3, MIN_LOW=2.
module tb_level_generator;

    typedef struct {
        int       idx;
        logic [2:0] exp;
    } expItem_t;

    logic clk;
    logic rst_n;
    logic pulse_in_p;
    logic pulse_in_n;
    logic sig_out;
    logic busy;
    logic conflict;

    expItem_t expQueue[$];
    int       vecCount;
    int       checkCount;
    int       failCount;

    level_generator #(
        .MIN_HIGH (3),
        .MIN_LOW  (2),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_in_p (pulse_in_p),
        .pulse_in_n (pulse_in_n),
        .sig_out    (sig_out),
        .busy       (busy),
        .conflict   (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for this cycle go on at the falling edge; the expected triple is
    // what the outputs must show during this same cycle (async reset included).
    task automatic applyStimulus(input logic rst, input logic p, input logic n,
                                 input logic eSig, input logic eBusy, input logic eConf);
        expItem_t item;
        @(negedge clk);
        rst_n      = rst;
        pulse_in_p = p;
        pulse_in_n = n;
        item.idx   = vecCount;
        item.exp   = {eSig, eBusy, eConf};
        expQueue.push_back(item);
        vecCount++;
    endtask

    task automatic checkOutput(input expItem_t item);
        logic [2:0] got;
        got = {sig_out, busy, conflict};
        checkCount++;
        if (got !== item.exp) begin
            failCount++;
            $display("[TB] FAIL vec%0d sig/busy/conflict got %b expected %b", item.idx, got, item.exp);
        end
    endtask

    initial begin : monitor
        expItem_t item;
        forever begin
            @(negedge clk);
            #1;
            if (expQueue.size() > 0) begin
                item = expQueue.pop_front();
                checkOutput(item);
            end
        end
    end

    initial begin : stimulus
        int waitCycles;
        vecCount   = 0;
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        pulse_in_p = 1'b0;
        pulse_in_n = 1'b0;

        // reset state, requests during reset ignored
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // plain rise: three held-high cycles then idle high
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        // plain fall, then redundant low request ignored
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // late fall request held pending until high hold expires
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // fall, then pending fall cancelled by a later rise request
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // pending rise during low hold, and a live rise at low expiry
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);

        // simultaneous requests in idle-high, hold-low and idle-low
        applyStimulus(1, 1, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 1);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // simultaneous requests leave an already-set pending flag alone
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // reset mid-hold with a pending fall; rise accepted right at release
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);

        waitCycles = 0;
        while (expQueue.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        #2;
        if (expQueue.size() > 0) begin
            failCount++;
            $display("[TB] FAIL drain %0d expectations left unchecked, required 0", expQueue.size());
        end
        if (checkCount != vecCount) begin
            failCount++;
            $display("[TB] FAIL checkCount got %0d required %0d", checkCount, vecCount);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
